// File: rtl/vga_sync_rx.sv
// Sync receiver: measures hsync/vsync timing, tracks raster position and
// declares lock after LOCK_FRAMES consecutive frames with stable geometry.
module vga_sync_rx #(
    parameter int HC_BITS     = 10,
    parameter int VC_BITS     = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync,
    input  logic               vsync,
    output logic [HC_BITS-1:0] hpos,
    output logic [VC_BITS-1:0] vpos,
    output logic [HC_BITS-1:0] h_total,
    output logic [HC_BITS-1:0] h_sync_w,
    output logic [VC_BITS-1:0] v_total,
    output logic [VC_BITS-1:0] v_sync_w,
    output logic               line_start,
    output logic               frame_start,
    output logic               lock_err,
    output logic               locked,
    output logic               no_signal
);
    localparam int GC_BITS = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_t;

    logic               r_hs_d, r_vs_d;
    logic [HC_BITS-1:0] r_hpos, r_h_total, r_h_sync_w;
    logic [VC_BITS-1:0] r_vpos, r_v_total, r_v_sync_w, r_vs_cnt;
    logic               r_line_start, r_frame_start, r_line_mismatch, r_no_signal;
    logic               r_lock_err;
    state_t             r_state, w_state_nx;
    logic [GC_BITS-1:0] r_good_cnt, w_good_cnt_nx, w_good_inc;
    logic               w_lock_err_nx;

    logic               w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic [HC_BITS-1:0] w_hpos_inc;
    logic [VC_BITS-1:0] w_vpos_rise;
    logic               w_hpos_max, w_line_bad, w_v_match, w_frame_good, w_sat;

    assign w_hs_rise    = hsync & ~r_hs_d;
    assign w_hs_fall    = ~hsync & r_hs_d;
    assign w_vs_rise    = vsync & ~r_vs_d;
    assign w_vs_fall    = ~vsync & r_vs_d;
    assign w_hpos_inc   = r_hpos + HC_BITS'(1);
    assign w_hpos_max   = &r_hpos;
    // A line ending on the vsync-rise cycle still belongs to the ending frame.
    assign w_vpos_rise  = r_vpos + VC_BITS'(w_hs_rise);
    assign w_line_bad   = w_hs_rise & (w_hpos_inc != r_h_total);
    assign w_v_match    = (w_vpos_rise == r_v_total);
    assign w_frame_good = w_v_match & ~r_line_mismatch;
    assign w_sat        = w_hpos_max & ~w_hs_rise;
    assign w_good_inc   = r_good_cnt + GC_BITS'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_d          <= 1'b0;
            r_vs_d          <= 1'b0;
            r_hpos          <= '0;
            r_vpos          <= '0;
            r_h_total       <= '0;
            r_h_sync_w      <= '0;
            r_v_total       <= '0;
            r_v_sync_w      <= '0;
            r_vs_cnt        <= '0;
            r_line_start    <= 1'b0;
            r_frame_start   <= 1'b0;
            r_line_mismatch <= 1'b0;
            r_no_signal     <= 1'b0;
        end else begin
            r_hs_d        <= hsync;
            r_vs_d        <= vsync;
            r_line_start  <= w_hs_rise;
            r_frame_start <= w_vs_rise;

            if (w_hs_rise) begin
                r_hpos    <= '0;
                r_h_total <= w_hpos_inc;
            end else if (!w_hpos_max) begin
                r_hpos <= w_hpos_inc;
            end
            if (w_hs_fall) r_h_sync_w <= w_hpos_inc;

            if (w_vs_rise) begin
                r_v_total <= w_vpos_rise;
                r_vpos    <= '0;
            end else if (w_hs_rise && !(&r_vpos)) begin
                r_vpos <= r_vpos + VC_BITS'(1);
            end

            if (w_vs_rise)             r_vs_cnt <= VC_BITS'(w_hs_rise);
            else if (vsync && w_hs_rise) r_vs_cnt <= r_vs_cnt + VC_BITS'(1);
            if (w_vs_fall) r_v_sync_w <= r_vs_cnt;

            if (w_vs_rise)       r_line_mismatch <= 1'b0;
            else if (w_line_bad) r_line_mismatch <= 1'b1;

            if (w_hs_rise)  r_no_signal <= 1'b0;
            else if (w_sat) r_no_signal <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_good_cnt <= w_good_cnt_nx;
            r_lock_err <= w_lock_err_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_good_cnt_nx = r_good_cnt;
        w_lock_err_nx = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_rise) begin
                    w_state_nx    = ST_TRACK;
                    w_good_cnt_nx = '0;
                end
            end
            ST_TRACK: begin
                if (w_vs_rise) begin
                    if (w_frame_good) begin
                        w_good_cnt_nx = w_good_inc;
                        if (w_good_inc == GC_BITS'(LOCK_FRAMES)) w_state_nx = ST_LOCKED;
                    end else begin
                        w_good_cnt_nx = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_line_bad || (w_vs_rise && !w_v_match)) begin
                    w_state_nx    = ST_SEARCH;
                    w_lock_err_nx = 1'b1;
                end
            end
            default: w_state_nx = ST_SEARCH;
        endcase
        // Loss of hsync overrides everything; only a drop out of lock is an error.
        if (w_sat) begin
            w_state_nx    = ST_SEARCH;
            w_lock_err_nx = (r_state == ST_LOCKED);
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign h_total     = r_h_total;
    assign h_sync_w    = r_h_sync_w;
    assign v_total     = r_v_total;
    assign v_sync_w    = r_v_sync_w;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign lock_err    = r_lock_err;
    assign locked      = (r_state == ST_LOCKED);
    assign no_signal   = r_no_signal;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx: a parameterised sync generator feeds the
// receiver and each scenario checks hand-derived outputs.
module tb_vga_sync_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [9:0] hpos, vpos, h_total, h_sync_w, v_total, v_sync_w;
    logic       line_start, frame_start, lock_err, locked, no_signal;

    int n_vec = 0;
    int n_err = 0;

    // generator state: hc/lc are the next position to be driven
    int hc = 0, lc = 0;
    int g_hlen = 40, g_hsw = 4, g_vlen = 12, g_vsw = 2, g_long_lc = -1;
    bit g_align = 1'b0;

    vga_sync_rx #(.HC_BITS(10), .VC_BITS(10), .LOCK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .hpos(hpos), .vpos(vpos), .h_total(h_total), .h_sync_w(h_sync_w),
        .v_total(v_total), .v_sync_w(v_sync_w), .line_start(line_start),
        .frame_start(frame_start), .lock_err(lock_err), .locked(locked),
        .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic gen_cycle();
        int len, p;
        len = (lc == g_long_lc) ? g_hlen + 1 : g_hlen;
        p = lc * g_hlen + hc;
        hsync = (hc < g_hsw);
        if (g_align) vsync = (p < g_vsw * g_hlen);
        else         vsync = (p >= g_hlen - 3) && (p < g_vsw * g_hlen + g_hlen - 3);
        @(posedge clk); #1;
        hc++;
        if (hc >= len) begin
            hc = 0;
            lc = (lc + 1 == g_vlen) ? 0 : lc + 1;
        end
    endtask

    task automatic gen_n(input int n);
        for (int i = 0; i < n; i++) gen_cycle();
    endtask

    task automatic run_to(input int tlc, input int thc);
        int guard;
        guard = 0;
        while (!(lc == tlc && hc == thc) && guard < 2000) begin
            gen_cycle();
            guard++;
        end
        n_vec++;
        if (guard >= 2000) begin
            $display("FAIL run_to timeout: at line %0d col %0d, target %0d/%0d", lc, hc, tlc, thc);
            n_err++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; hsync = 1'b0; vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        hc = 0; lc = 0; g_long_lc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; hsync = 1'b0; vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (hpos !== 10'd0) begin $display("FAIL rst_hpos: got %0d want 0", hpos); n_err++; end
        n_vec++; if (vpos !== 10'd0) begin $display("FAIL rst_vpos: got %0d want 0", vpos); n_err++; end
        n_vec++; if (h_total !== 10'd0 || h_sync_w !== 10'd0) begin $display("FAIL rst_hmeas: got %0d/%0d want 0/0", h_total, h_sync_w); n_err++; end
        n_vec++; if (v_total !== 10'd0 || v_sync_w !== 10'd0) begin $display("FAIL rst_vmeas: got %0d/%0d want 0/0", v_total, v_sync_w); n_err++; end
        n_vec++; if ({line_start, frame_start, lock_err, locked, no_signal} !== 5'b0) begin
            $display("FAIL rst_flags: got %b want 00000", {line_start, frame_start, lock_err, locked, no_signal}); n_err++; end
    endtask

    task automatic test_pulses();
        g_hlen = 16; g_hsw = 2; g_vlen = 12; g_vsw = 2; g_align = 1'b0;
        do_reset();
        gen_cycle();
        n_vec++; if (line_start !== 1'b1 || hpos !== 10'd0) begin $display("FAIL ls_first: line_start=%b hpos=%0d want 1/0", line_start, hpos); n_err++; end
        n_vec++; if (frame_start !== 1'b0 || vpos !== 10'd1) begin $display("FAIL fs_first: frame_start=%b vpos=%0d want 0/1", frame_start, vpos); n_err++; end
        gen_cycle();
        n_vec++; if (line_start !== 1'b0 || hpos !== 10'd1) begin $display("FAIL ls_second: line_start=%b hpos=%0d want 0/1", line_start, hpos); n_err++; end
        gen_n(11);
        n_vec++; if (frame_start !== 1'b0 || vpos !== 10'd1) begin $display("FAIL fs_before: frame_start=%b vpos=%0d want 0/1", frame_start, vpos); n_err++; end
        gen_cycle();
        n_vec++; if (frame_start !== 1'b1 || vpos !== 10'd0 || hpos !== 10'd13) begin
            $display("FAIL fs_pulse: frame_start=%b vpos=%0d hpos=%0d want 1/0/13", frame_start, vpos, hpos); n_err++; end
        gen_cycle();
        n_vec++; if (frame_start !== 1'b0 || line_start !== 1'b0) begin $display("FAIL fs_after: frame_start=%b line_start=%b want 0/0", frame_start, line_start); n_err++; end
    endtask

    task automatic test_hmeas();
        g_hlen = 800; g_hsw = 96; g_vlen = 525; g_vsw = 2; g_align = 1'b0;
        do_reset();
        gen_n(1700);
        n_vec++; if (h_total !== 10'd800) begin $display("FAIL h_total_800: got %0d want 800", h_total); n_err++; end
        n_vec++; if (h_sync_w !== 10'd96) begin $display("FAIL h_sync_w_96: got %0d want 96", h_sync_w); n_err++; end
        n_vec++; if (hpos !== 10'd99 || vpos !== 10'd2) begin $display("FAIL pos_1700: hpos=%0d vpos=%0d want 99/2", hpos, vpos); n_err++; end
    endtask

    task automatic test_vmeas();
        g_hlen = 16; g_hsw = 2; g_vlen = 525; g_vsw = 2; g_align = 1'b0;
        do_reset();
        gen_n(8500);
        n_vec++; if (v_total !== 10'd525) begin $display("FAIL v_total_525: got %0d want 525", v_total); n_err++; end
        n_vec++; if (v_sync_w !== 10'd2) begin $display("FAIL v_sync_w_2: got %0d want 2", v_sync_w); n_err++; end
        n_vec++; if (h_total !== 10'd16 || h_sync_w !== 10'd2) begin $display("FAIL hmeas_16: got %0d/%0d want 16/2", h_total, h_sync_w); n_err++; end
    endtask

    task automatic test_lock();
        g_hlen = 40; g_hsw = 4; g_vlen = 12; g_vsw = 2; g_align = 1'b0;
        do_reset();
        gen_n(1477);
        n_vec++; if (locked !== 1'b0) begin $display("FAIL lock_early: locked=%b want 0", locked); n_err++; end
        gen_cycle();
        n_vec++; if (locked !== 1'b1) begin $display("FAIL lock_4th_vs: locked=%b want 1", locked); n_err++; end
        n_vec++; if (h_total !== 10'd40 || h_sync_w !== 10'd4 || v_total !== 10'd12 || v_sync_w !== 10'd2) begin
            $display("FAIL lock_meas: got %0d/%0d/%0d/%0d want 40/4/12/2", h_total, h_sync_w, v_total, v_sync_w); n_err++; end
    endtask

    task automatic test_long_line();
        g_long_lc = 6;
        run_to(7, 0);
        n_vec++; if (locked !== 1'b1 || lock_err !== 1'b0) begin $display("FAIL long_pre: locked=%b lock_err=%b want 1/0", locked, lock_err); n_err++; end
        gen_cycle();
        g_long_lc = -1;
        n_vec++; if (lock_err !== 1'b1 || locked !== 1'b0) begin $display("FAIL long_err: lock_err=%b locked=%b want 1/0", lock_err, locked); n_err++; end
        n_vec++; if (h_total !== 10'd41) begin $display("FAIL long_h_total: got %0d want 41", h_total); n_err++; end
        gen_cycle();
        n_vec++; if (lock_err !== 1'b0) begin $display("FAIL long_err_width: lock_err=%b want 0", lock_err); n_err++; end
        run_to(0, 37); gen_cycle();
        run_to(0, 37); gen_cycle();
        run_to(0, 37);
        n_vec++; if (locked !== 1'b0) begin $display("FAIL relock_early: locked=%b want 0", locked); n_err++; end
        gen_cycle();
        n_vec++; if (locked !== 1'b1) begin $display("FAIL relock_3rd_vs: locked=%b want 1", locked); n_err++; end
    endtask

    task automatic test_no_signal();
        int pulses, hpos_at;
        logic ns_at;
        pulses = 0; hpos_at = -1; ns_at = 1'b0;
        run_to(6, 0);
        hsync = 1'b0; vsync = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            if (lock_err === 1'b1) begin
                pulses++;
                hpos_at = int'(hpos);
                ns_at = no_signal;
            end
        end
        n_vec++; if (pulses != 1) begin $display("FAIL ns_pulses: got %0d lock_err pulses want 1", pulses); n_err++; end
        n_vec++; if (hpos_at != 1023 || ns_at !== 1'b1) begin $display("FAIL ns_at_pulse: hpos=%0d no_signal=%b want 1023/1", hpos_at, ns_at); n_err++; end
        n_vec++; if (no_signal !== 1'b1 || locked !== 1'b0 || hpos !== 10'd1023) begin
            $display("FAIL ns_hold: no_signal=%b locked=%b hpos=%0d want 1/0/1023", no_signal, locked, hpos); n_err++; end
        gen_cycle();
        n_vec++; if (no_signal !== 1'b0 || hpos !== 10'd0 || line_start !== 1'b1) begin
            $display("FAIL ns_clear: no_signal=%b hpos=%0d line_start=%b want 0/0/1", no_signal, hpos, line_start); n_err++; end
    endtask

    task automatic test_aligned();
        g_hlen = 40; g_hsw = 4; g_vlen = 12; g_vsw = 2; g_align = 1'b1;
        do_reset();
        gen_cycle();
        n_vec++; if (vpos !== 10'd0 || hpos !== 10'd0 || frame_start !== 1'b1 || line_start !== 1'b1) begin
            $display("FAIL al_first: vpos=%0d hpos=%0d fs=%b ls=%b want 0/0/1/1", vpos, hpos, frame_start, line_start); n_err++; end
        gen_n(1439);
        n_vec++; if (locked !== 1'b0) begin $display("FAIL al_lock_early: locked=%b want 0", locked); n_err++; end
        gen_cycle();
        n_vec++; if (locked !== 1'b1) begin $display("FAIL al_lock_4th_vs: locked=%b want 1", locked); n_err++; end
        n_vec++; if (v_total !== 10'd12 || v_sync_w !== 10'd2 || vpos !== 10'd0) begin
            $display("FAIL al_vmeas: v_total=%0d v_sync_w=%0d vpos=%0d want 12/2/0", v_total, v_sync_w, vpos); n_err++; end
    endtask

    task automatic test_reset_locked();
        reset = 1'b1;
        gen_cycle();
        n_vec++; if (locked !== 1'b0 || lock_err !== 1'b0) begin $display("FAIL rl_state: locked=%b lock_err=%b want 0/0", locked, lock_err); n_err++; end
        n_vec++; if (hpos !== 10'd0 || h_total !== 10'd0 || v_total !== 10'd0) begin
            $display("FAIL rl_regs: hpos=%0d h_total=%0d v_total=%0d want 0/0/0", hpos, h_total, v_total); n_err++; end
        reset = 1'b0;
        gen_cycle();
        n_vec++; if (lock_err !== 1'b0) begin $display("FAIL rl_after: lock_err=%b want 0", lock_err); n_err++; end
    endtask

    initial begin
        test_reset();
        test_pulses();
        test_hmeas();
        test_vmeas();
        test_lock();
        test_long_line();
        test_no_signal();
        test_aligned();
        test_reset_locked();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
